wb_slave_arb: RTL and testbench

WB_SLAVE_ARB -- requirements
Module: wb_slave_arb

---
 rtl/wb_slave_arb.sv | 170 +++++++++++++++++
 tb/tb_wb_slave_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_arb.sv
// rtl/wb_slave_arb.sv - Wishbone address-window arbiter with slave timeout and error reporting
// Forwards upstream requests to one of two 4 KB slave windows or local registers.

module wb_slave_arb #(
  parameter logic [31:0] NEURO_BASE  = 32'h3000_0000,
  parameter logic [31:0] MATMUL_BASE = 32'h3100_0000,
  parameter logic [31:0] CTRL_BASE   = 32'h3200_0000,
  parameter logic [31:0] WIN_MASK    = 32'hFFFF_F000,
  parameter logic [7:0]  TIMEOUT_RST = 8'd64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        s0_cyc_o,
  output logic        s0_stb_o,
  input  logic        s0_ack_i,
  input  logic [31:0] s0_dat_i,
  output logic        s1_cyc_o,
  output logic        s1_stb_o,
  input  logic        s1_ack_i,
  input  logic [31:0] s1_dat_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {IDLE, FWD0, FWD1, LOCAL, ERR, RESP} state_t;

  state_t      state;
  logic        s0_act, s1_act;
  logic [7:0]  wait_cnt, timeout_reg, err_cnt;
  logic [31:0] err_addr;
  logic        err_flag, irq_en;

  logic [31:0] win;
  logic [7:0]  wait_nxt;
  logic        tmo_hit;
  logic        fwd_ack;
  logic [31:0] fwd_dat;
  logic [31:0] local_rdata;

  assign s0_cyc_o = s0_act;
  assign s0_stb_o = s0_act;
  assign s1_cyc_o = s1_act;
  assign s1_stb_o = s1_act;

  assign win      = wbs_adr_i & WIN_MASK;
  assign wait_nxt = wait_cnt + 8'd1;
  // Timeout fires at the end of the TIMEOUT-th strobe cycle; zero disables it.
  assign tmo_hit  = (timeout_reg != 8'd0) && (wait_nxt == timeout_reg);
  assign fwd_ack  = (state == FWD1) ? s1_ack_i : s0_ack_i;
  assign fwd_dat  = (state == FWD1) ? s1_dat_i : s0_dat_i;

  always_comb begin
    local_rdata = 32'h0;
    case (m_adr_o[11:0])
      12'h000: local_rdata = {16'h0, err_cnt, 6'h0, err_flag, irq_en};
      12'h004: local_rdata = err_addr;
      12'h008: local_rdata = {24'h0, timeout_reg};
      default: local_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      s0_act      <= 1'b0;
      s1_act      <= 1'b0;
      wait_cnt    <= 8'd0;
      timeout_reg <= TIMEOUT_RST;
      err_cnt     <= 8'd0;
      err_addr    <= 32'h0;
      err_flag    <= 1'b0;
      irq_en      <= 1'b0;
      irq_o       <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'h0;
      m_we_o      <= 1'b0;
      m_sel_o     <= 4'h0;
      m_adr_o     <= 32'h0;
      m_dat_o     <= 32'h0;
    end else begin
      irq_o <= err_flag & irq_en;
      case (state)
        IDLE: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= 32'h0;
          if (wbs_cyc_i && wbs_stb_i) begin
            m_we_o   <= wbs_we_i;
            m_sel_o  <= wbs_sel_i;
            m_adr_o  <= wbs_adr_i;
            m_dat_o  <= wbs_dat_i;
            wait_cnt <= 8'd0;
            if (win == NEURO_BASE) begin
              state  <= FWD0;
              s0_act <= 1'b1;
            end else if (win == MATMUL_BASE) begin
              state  <= FWD1;
              s1_act <= 1'b1;
            end else if (win == CTRL_BASE) begin
              state <= LOCAL;
            end else begin
              state <= ERR;
            end
          end
        end
        FWD0, FWD1: begin
          // Abort beats ack, and ack beats a coincident timeout.
          if (!wbs_cyc_i) begin
            s0_act <= 1'b0;
            s1_act <= 1'b0;
            state  <= IDLE;
          end else if (fwd_ack) begin
            s0_act    <= 1'b0;
            s1_act    <= 1'b0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= fwd_dat;
            state     <= RESP;
          end else if (tmo_hit) begin
            s0_act <= 1'b0;
            s1_act <= 1'b0;
            state  <= ERR;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        LOCAL: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= m_we_o ? 32'h0 : local_rdata;
          if (m_we_o && m_sel_o[0]) begin
            case (m_adr_o[11:0])
              12'h000: begin
                irq_en <= m_dat_o[0];
                if (m_dat_o[1]) err_flag <= 1'b0;
                if (m_dat_o[2]) err_cnt  <= 8'd0;
              end
              12'h008: timeout_reg <= m_dat_o[7:0];
              default: ;
            endcase
          end
          state <= RESP;
        end
        ERR: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= 32'hDEAD_BEEF;
          err_flag  <= 1'b1;
          err_addr  <= m_adr_o;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state <= RESP;
        end
        RESP: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= 32'h0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_arb.sv
// tb/tb_wb_slave_arb.sv - Scoreboard bench for wb_slave_arb
// Expected ack data is queued per request and popped by the ack monitor.

module tb_wb_slave_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat;
  logic        s0_cyc, s0_stb, s1_cyc, s1_stb;
  logic        s0_ack = 1'b0, s1_ack = 1'b0;
  logic [31:0] s0_dat = 32'h0, s1_dat = 32'h0;
  logic        irq;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  int          lat0 = 0, lat1 = 0;   // strobe cycle on which slave acks; 0 = never
  int          c0 = 0, c1 = 0;
  int          s0_tot = 0, s1_tot = 0;

  localparam logic [31:0] CTRL = 32'h3200_0000;

  always #5 clk = ~clk;

  wb_slave_arb dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m_we_o(m_we), .m_sel_o(m_sel), .m_adr_o(m_adr), .m_dat_o(m_dat),
    .s0_cyc_o(s0_cyc), .s0_stb_o(s0_stb), .s0_ack_i(s0_ack), .s0_dat_i(s0_dat),
    .s1_cyc_o(s1_cyc), .s1_stb_o(s1_stb), .s1_ack_i(s1_ack), .s1_dat_i(s1_dat),
    .irq_o(irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave models and ack/scoreboard monitor, all sampled on the falling edge.
  always @(negedge clk) begin
    if (s0_stb) begin c0++; s0_tot++; s0_ack = (lat0 != 0) && (c0 == lat0); end
    else begin c0 = 0; s0_ack = 1'b0; end
    if (s1_stb) begin c1++; s1_tot++; s1_ack = (lat1 != 0) && (c1 == lat1); end
    else begin c1 = 0; s1_ack = 1'b0; end
    if (ack) begin
      if (sb.size() == 0) check_eq("unexpected_ack", {31'h0, ack}, 32'h0);
      else check_eq("ack_data", rdat, sb.pop_front());
    end else begin
      check_eq("dat_zero_idle", rdat, 32'h0);
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] s, input logic [31:0] exp, output int lat);
    sb.push_back(exp);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 200);
    if (!ack) begin
      check_eq("ack_seen", 32'h0, 32'h1);
      void'(sb.pop_back());
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd_local(input logic [11:0] off, input logic [31:0] exp);
    int l;
    xfer(CTRL | {20'h0, off}, 32'h0, 1'b0, 4'hF, exp, l);
  endtask

  task automatic wr_local(input logic [11:0] off, input logic [31:0] d, input logic [3:0] s);
    int l;
    xfer(CTRL | {20'h0, off}, d, 1'b1, s, 32'h0, l);
  endtask

  initial begin
    int l, snap;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", {31'h0, ack}, 32'h0);
    check_eq("rst_s0", {30'h0, s0_cyc, s0_stb}, 32'h0);
    check_eq("rst_s1", {30'h0, s1_cyc, s1_stb}, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_madr", m_adr, 32'h0);
    check_eq("rst_mmisc", {27'h0, m_we, m_sel}, 32'h0);
    rst_n = 1'b1;
    rd_local(12'h008, 32'h40);
    rd_local(12'h000, 32'h0);
    rd_local(12'h004, 32'h0);

    // Zero-wait slave: ack two cycles after the request.
    lat0 = 1; s0_dat = 32'hCAFE_0001;
    xfer(32'h3000_0000, 32'h0, 1'b0, 4'hF, 32'hCAFE_0001, l);
    check_eq("lat_fwd0", l, 2);

    snap = s1_tot; lat0 = 4; s0_dat = 32'h1234_5678;
    xfer(32'h3000_0010, 32'h0, 1'b0, 4'hF, 32'h1234_5678, l);
    check_eq("lat_fwd0_wait", l, 5);
    check_eq("s1_quiet", s1_tot - snap, 0);

    wr_local(12'h000, 32'h1, 4'hF);
    snap = s1_tot; lat1 = 0;
    xfer(32'h3100_0004, 32'hA5, 1'b1, 4'hF, 32'hDEAD_BEEF, l);
    check_eq("tmo_strobes", s1_tot - snap, 64);
    check_eq("m_adr_latch", m_adr, 32'h3100_0004);
    check_eq("m_dat_latch", m_dat, 32'hA5);
    check_eq("m_we_sel", {27'h0, m_we, m_sel}, 32'h1F);
    @(negedge clk);
    check_eq("irq_set", {31'h0, irq}, 32'h1);
    rd_local(12'h004, 32'h3100_0004);
    rd_local(12'h000, 32'h0000_0103);

    xfer(32'h3300_0000, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, l);
    check_eq("lat_err", l, 2);
    rd_local(12'h000, 32'h0000_0203);
    for (int i = 0; i < 255; i++) xfer(32'h3300_0000, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, l);
    rd_local(12'h000, 32'h0000_FF03);
    rd_local(12'h004, 32'h3300_0000);

    sb.push_back(32'h0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = CTRL; wdat = 32'h6;
    @(negedge clk);
    @(negedge clk);
    check_eq("lat_local", {31'h0, ack}, 32'h1);
    check_eq("irq_still", {31'h0, irq}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check_eq("irq_fall", {31'h0, irq}, 32'h0);
    rd_local(12'h000, 32'h0);

    // Timeout disabled: silent slave keeps strobes up until the master gives up.
    wr_local(12'h008, 32'h0, 4'hF);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0000;
    repeat (300) @(negedge clk);
    check_eq("tmo0_held", {31'h0, s1_stb}, 32'h1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check_eq("abort_drop", {30'h0, s1_cyc, s1_stb}, 32'h0);
    rd_local(12'h000, 32'h0);

    wr_local(12'h008, 32'h5, 4'h2);
    rd_local(12'h008, 32'h0);
    wr_local(12'h008, 32'h4, 4'h1);
    rd_local(12'h008, 32'h4);

    lat1 = 4; s1_dat = 32'h0BAD_F00D;
    xfer(32'h3100_0020, 32'h0, 1'b0, 4'hF, 32'h0BAD_F00D, l);
    rd_local(12'h000, 32'h0);
    lat1 = 3; s1_dat = 32'h0000_0033;
    xfer(32'h3100_0024, 32'h0, 1'b0, 4'hF, 32'h0000_0033, l);
    snap = s1_tot; lat1 = 0;
    xfer(32'h3100_0028, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, l);
    check_eq("tmo4_strobes", s1_tot - snap, 4);
    rd_local(12'h000, 32'h0000_0102);

    // Asynchronous reset in the middle of a forward.
    wr_local(12'h000, 32'h1, 4'hF);
    lat0 = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h3; adr = 32'h3000_0040; wdat = 32'h77;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_s0", {31'h0, s0_cyc}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_s0", {30'h0, s0_cyc, s0_stb}, 32'h0);
    check_eq("async_madr", m_adr, 32'h0);
    check_eq("async_irq", {31'h0, irq}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rd_local(12'h008, 32'h40);
    rd_local(12'h000, 32'h0);
    rd_local(12'h004, 32'h0);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
